// File: rtl/layer_output_streamer_if.sv
// Stream/control bundle between the neuron result registers, the vector
// streamer and the downstream consumer.
interface layer_output_streamer_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
);
  logic                    load;
  logic [DEPTH*DATA_W-1:0] data_in;
  logic                    busy;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    done;

  modport master (
    output load, data_in, out_ready,
    input  busy, out_data, out_valid, out_last, done
  );

  modport slave (
    input  load, data_in, out_ready,
    output busy, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/layer_output_streamer.sv
// Captures a whole layer result vector in one cycle and replays it one element
// at a time on a valid/ready stream, pulsing done once the last element leaves.
module layer_output_streamer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  layer_output_streamer_if.slave                   bus
);

  localparam int                 IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [IDX_W-1:0]  r_idx;

  logic              w_at_last;
  logic              w_xfer;
  logic              w_capture;
  logic              w_busy;
  logic              w_valid;
  logic              w_last;
  logic              w_done;
  logic [DATA_W-1:0] w_data;

  assign w_at_last = (r_idx == LAST_IDX);
  assign w_xfer    = (r_state == STREAM) && bus.out_ready;
  assign w_capture = (r_state == IDLE) && bus.load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Loads arriving outside IDLE never touch the buffer, so a vector in flight
  // is immune to later changes on data_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_idx <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= bus.data_in[i*DATA_W +: DATA_W];
      end
      r_idx <= '0;
    end else if (w_xfer && !w_at_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_done      = 1'b0;
    w_data      = '0;
    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        w_data  = r_buf[r_idx];
        w_last  = w_at_last;
        if (bus.out_ready && w_at_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy      = w_busy;
  assign bus.out_valid = w_valid;
  assign bus.out_last  = w_last;
  assign bus.done      = w_done;
  assign bus.out_data  = w_data;

endmodule

// File: tb/tb_layer_output_streamer.sv
// Directed vector table plus hand-written reset and random-backpressure
// sequences for the layer output streamer.
module tb_layer_output_streamer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int VEC_W  = DEPTH * DATA_W;

  logic clk;
  logic resetN;

  int vectors;
  int miscompares;

  layer_output_streamer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) busIf ();

  layer_output_streamer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (resetN),
    .bus   (busIf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic             load;
    logic             useB;
    logic             ready;
    logic             expBusy;
    logic             expValid;
    logic             expLast;
    logic             expDone;
    logic [DATA_W-1:0] expData;
  } vec_t;

  vec_t table_q[$];

  logic [VEC_W-1:0] vecA;
  logic [VEC_W-1:0] vecB;

  function automatic vec_t mk(logic ld, logic b, logic rdy, logic eb, logic ev,
                              logic el, logic ed, logic [DATA_W-1:0] edata);
    vec_t v;
    v.load = ld; v.useB = b; v.ready = rdy;
    v.expBusy = eb; v.expValid = ev; v.expLast = el; v.expDone = ed;
    v.expData = edata;
    return v;
  endfunction

  // Data is only meaningful while valid, so it is masked out otherwise.
  function automatic logic [11:0] packOut(logic b, logic v, logic l, logic d,
                                          logic [DATA_W-1:0] data, logic useData);
    return {b, v, l, d, (useData ? data : 8'h00)};
  endfunction

  task automatic applyStimulus(input logic ld, input logic [VEC_W-1:0] din, input logic rdy);
    busIf.load      = ld;
    busIf.data_in   = din;
    busIf.out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkRow(input string name, input vec_t v);
    checkOutput(name,
      32'(packOut(busIf.busy, busIf.out_valid, busIf.out_last, busIf.done, busIf.out_data, v.expValid)),
      32'(packOut(v.expBusy, v.expValid, v.expLast, v.expDone, v.expData, v.expValid)));
  endtask

  logic [DATA_W-1:0] model [DEPTH];
  logic [VEC_W-1:0]  rndVec;
  logic              rdy;
  int                expIdx;
  int                cycles;
  bit                doneSeen;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) begin
      vecA[i*DATA_W +: DATA_W] = 8'(8'h10 + i);
      vecB[i*DATA_W +: DATA_W] = 8'(8'hAA + i);
    end

    // Rows: inputs driven at a falling edge, outputs checked one cycle later.
    table_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 8'h10));
    table_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h11));
    table_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h12));
    table_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h12));
    table_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h12));
    table_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h12));
    table_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h13));
    table_q.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h14));
    table_q.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h15));
    table_q.push_back(mk(0, 1, 1, 1, 1, 0, 0, 8'h16));
    table_q.push_back(mk(0, 1, 1, 1, 1, 1, 0, 8'h17));
    table_q.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'h00));
    table_q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 8'h00));
    table_q.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'hAA));
    for (int i = 1; i < DEPTH; i++) begin
      table_q.push_back(mk(0, 0, 1, 1, 1, (i == DEPTH-1), 0, 8'(8'hAA + i)));
    end
    table_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 8'h00));
    table_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h00));

    resetN = 1'b0;
    applyStimulus(1'b1, vecA, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("reset_state",
      32'(packOut(busIf.busy, busIf.out_valid, busIf.out_last, busIf.done, busIf.out_data, 1'b1)), 32'h0);
    applyStimulus(1'b0, vecA, 1'b1);
    resetN = 1'b1;
    @(negedge clk);

    foreach (table_q[r]) begin
      applyStimulus(table_q[r].load, table_q[r].useB ? vecB : vecA, table_q[r].ready);
      @(negedge clk);
      checkRow($sformatf("table_row%0d", r), table_q[r]);
    end

    // Reset asserted between clock edges while idx=4 is being shown.
    applyStimulus(1'b1, vecA, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, vecA, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("midrst_pre_data", 32'(busIf.out_data), 32'h14);
    #2 resetN = 1'b0;
    #1 checkOutput("midrst_outputs",
      32'(packOut(busIf.busy, busIf.out_valid, busIf.out_last, busIf.done, busIf.out_data, 1'b1)), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("midrst_idle_busy", 32'(busIf.busy), 32'h0);
    applyStimulus(1'b1, vecB, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, vecB, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("restart_elem%0d", i),
        32'({busIf.out_valid, busIf.out_last, busIf.out_data}),
        32'({1'b1, (i == DEPTH-1), 8'(8'hAA + i)}));
      @(negedge clk);
    end
    checkOutput("restart_done", 32'({busIf.done, busIf.out_valid}), 32'b10);
    @(negedge clk);

    // Random data and 50% backpressure, element-by-element scoreboard.
    for (int v = 0; v < 100; v++) begin
      for (int i = 0; i < DEPTH; i++) begin
        model[i] = 8'($urandom_range(0, 255));
        rndVec[i*DATA_W +: DATA_W] = model[i];
      end
      applyStimulus(1'b1, rndVec, 1'($urandom_range(0, 1)));
      @(negedge clk);
      applyStimulus(1'b0, ~rndVec, 1'b0);
      expIdx   = 0;
      cycles   = 0;
      doneSeen = 0;
      while (!doneSeen && cycles < 200) begin
        checkOutput("rnd_valid", 32'(busIf.out_valid), 32'(expIdx < DEPTH));
        if (expIdx == DEPTH) begin
          checkOutput("rnd_done", 32'(busIf.done), 32'h1);
          doneSeen = 1;
        end else begin
          rdy = 1'($urandom_range(0, 1));
          busIf.out_ready = rdy;
          if (rdy) begin
            checkOutput($sformatf("rnd_v%0d_elem%0d", v, expIdx),
              32'({busIf.out_last, busIf.out_data}),
              32'({(expIdx == DEPTH-1), model[expIdx]}));
            expIdx++;
          end
          @(negedge clk);
          cycles++;
        end
      end
      if (!doneSeen) begin
        miscompares++;
        $display("[TB] FAIL rnd_timeout: vector %0d got %0d elements expected %0d", v, expIdx, DEPTH);
      end
      @(negedge clk);
      checkOutput("rnd_done_pulse", 32'({busIf.done, busIf.busy}), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
